// File: rtl/uart_pkg.sv
// Shared types and constants for the controller-link UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Defaults for the 108 MHz controller link
  localparam int unsigned CLK_HZ_DEF      = 108_000_000;
  localparam int unsigned BAUD_DEF        = 115_200;
  localparam int unsigned OVERSAMPLE_DEF  = 16;
  localparam int unsigned DATA_BITS_DEF   = 8;
  localparam int unsigned FIFO_DEPTH_DEF  = 4;
  localparam int unsigned TIMEOUT_CYC_DEF = 10_800_000;

  // Clocks per oversample tick, rounded to nearest
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    longint unsigned num;
    longint unsigned den;
    num = 64'(clk_hz);
    den = 64'(baud) * 64'(os);
    return 32'((num + den / 2) / den);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through read port.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop on the same cycle frees the slot a full-FIFO push needs
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// Oversampled UART receive front-end with error flags, FIFO and link-loss detect.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ      = CLK_HZ_DEF,
  parameter int unsigned BAUD        = BAUD_DEF,
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS   = DATA_BITS_DEF,
  parameter parity_e     PARITY      = PAR_NONE,
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rxd,
  input  logic                 i_rd_en,
  input  logic                 i_clr_err,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overflow,
  output logic                 o_link_lost,
  output logic                 o_busy
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST      = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(DATA_BITS - 1);
  localparam logic [TO_W-1:0]  TO_MAX       = TO_W'(TIMEOUT_CYC);

  if (DIV < 2) begin : g_div_chk
    $error("uart_cmd_rx: clock divider below 2");
  end
  if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_os_chk
    $error("uart_cmd_rx: OVERSAMPLE must be even and >= 4");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_db_chk
    $error("uart_cmd_rx: DATA_BITS out of range");
  end

  rx_state_e            state;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_prev;
  logic                 rx_fall;
  logic                 start_det;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [TO_W-1:0]      idle_cnt;
  logic [OS_W-1:0]      os_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 par_ok;
  logic                 half_done;
  logic                 bit_done;
  logic                 stop_sample;
  logic                 push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_level_unused;

  assign rx_fall     = rx_prev & ~rx_s;
  assign start_det   = (state == ST_IDLE) && rx_fall;
  assign tick        = (div_cnt == DIV_LAST);
  assign half_done   = tick && (os_cnt == OS_HALF_LAST);
  assign bit_done    = tick && (os_cnt == OS_LAST);
  assign stop_sample = (state == ST_STOP) && bit_done;
  // Push is combinational on the stop tick so the byte is visible the next cycle
  assign push        = stop_sample && rx_s && par_ok;
  assign fifo_pop    = i_rd_en && !fifo_empty;
  assign o_valid     = !fifo_empty;
  assign o_busy      = (state != ST_IDLE);
  assign o_link_lost = (idle_cnt == TO_MAX);

  // Parity check against the completed data word
  always_comb begin
    par_ok = 1'b1;
    if (PARITY == PAR_EVEN)     par_ok = (par_bit == ^shift);
    else if (PARITY == PAR_ODD) par_ok = (par_bit == ~^shift);
  end

  // Two-flop synchroniser plus edge-detect history, idle-high
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rxd;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Oversample tick divider, phase-aligned to each start edge
  always_ff @(posedge i_clk) begin
    if (i_rst || start_det || tick) div_cnt <= '0;
    else                            div_cnt <= div_cnt + 1'b1;
  end

  // Saturating idle counter for link-loss detection
  always_ff @(posedge i_clk) begin
    if (i_rst)                   idle_cnt <= TO_MAX;
    else if (start_det)          idle_cnt <= '0;
    else if (idle_cnt != TO_MAX) idle_cnt <= idle_cnt + 1'b1;
  end

  // Frame decode state machine
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (rx_fall) begin
            state  <= ST_START;
            os_cnt <= '0;
          end
        end
        ST_START: begin
          if (half_done) begin
            os_cnt  <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else if (tick) begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            os_cnt <= '0;
            shift  <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) state <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            else                     bit_cnt <= bit_cnt + 1'b1;
          end else if (tick) begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            os_cnt  <= '0;
            par_bit <= rx_s;
            state   <= ST_STOP;
          end else if (tick) begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            os_cnt <= '0;
            state  <= rx_s ? ST_IDLE : ST_BREAK;
          end else if (tick) begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags; a set event overrides a same-cycle clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      if (i_clr_err) begin
        o_frame_err  <= 1'b0;
        o_parity_err <= 1'b0;
        o_overflow   <= 1'b0;
      end
      if (stop_sample && !rx_s)           o_frame_err  <= 1'b1;
      if (stop_sample && rx_s && !par_ok) o_parity_err <= 1'b1;
      if (push && fifo_full && !fifo_pop) o_overflow   <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (push),
    .wr_data (shift),
    .pop     (fifo_pop),
    .rd_data (o_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_level_unused)
  );

endmodule
